// File: rtl/pc_fetch_sequencer.sv
// Per-core program counter and instruction fetch sequencer: owns the PC, fetches one
// instruction at a time over a valid/ready request + valid response link, holds it until retired.
module pc_fetch_sequencer #(
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned INSTR_WIDTH = 16,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   Start,
    input  logic [PC_WIDTH-1:0]    StartPC,
    input  logic [PC_WIDTH-1:0]    NextPC,
    input  logic                   UpdatePC,
    input  logic                   Halt,
    output logic [PC_WIDTH-1:0]    CurrentPC,
    output logic [PC_WIDTH-1:0]    CurrentPCPlus,
    output logic                   MemReqValid,
    output logic [PC_WIDTH-1:0]    MemReqAddr,
    input  logic                   MemReqReady,
    input  logic                   MemRspValid,
    input  logic [INSTR_WIDTH-1:0] MemRspData,
    output logic [INSTR_WIDTH-1:0] Instruction,
    output logic                   InstrValid,
    output logic                   Busy,
    output logic                   Done,
    output logic [CNT_WIDTH-1:0]   RetireCount
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StHold,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   req_valid_q, instr_valid_q, busy_q, done_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (Start) begin
                    pc_d    = StartPC;
                    cnt_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (MemReqReady) state_d = StWait;
            end
            StWait: begin
                if (MemRspValid) begin
                    instr_d = MemRspData;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (UpdatePC) begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                    if (Halt) begin
                        state_d = StDone;
                    end else begin
                        pc_d    = NextPC;
                        state_d = StReq;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Status flags are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            pc_q          <= '0;
            instr_q       <= '0;
            cnt_q         <= '0;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            cnt_q         <= cnt_d;
            req_valid_q   <= (state_d == StReq);
            instr_valid_q <= (state_d == StHold);
            busy_q        <= (state_d == StReq) || (state_d == StWait) || (state_d == StHold);
            done_q        <= (state_d == StDone);
        end
    end

    assign CurrentPC     = pc_q;
    assign CurrentPCPlus = pc_q + PC_WIDTH'(1);
    assign MemReqAddr    = pc_q;
    assign MemReqValid   = req_valid_q;
    assign Instruction   = instr_q;
    assign InstrValid    = instr_valid_q;
    assign Busy          = busy_q;
    assign Done          = done_q;
    assign RetireCount   = cnt_q;

endmodule
